// File: rtl/mc_controller.sv
// mc_controller: Moore FSM control unit for the multi-cycle MIPS datapath.
// Optional feature macro: MC_BNE_EN (decode op 000101 as bne through state BNEEX).
module mc_controller #(
    parameter bit ILLEGAL_TRAP = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  op,
    input  logic [5:0]  funct,
    output logic [3:0]  state,
    output logic [15:0] controlword,
    output logic [2:0]  alucontrol,
    output logic        illegal
);
    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11,
        BNEEX   = 4'd12,
        UNUSED13 = 4'd13,
        UNUSED14 = 4'd14,
        HALT    = 4'd15
    } state_t;

    state_t state_q, state_d, dec_next;
    logic   dec_legal;

    // state register; reset abandons any instruction in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    assign state = state_q;

    // instruction decode: target state for DECODE and legality of op/funct
    always_comb begin
        dec_next  = FETCH;
        dec_legal = 1'b1;
        case (op)
            6'b100011, 6'b101011: dec_next = MEMADR;
            6'b000000: begin
                dec_next  = RTYPEEX;
                dec_legal = funct inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
            end
            6'b000100: dec_next = BEQEX;
            6'b001000: dec_next = ADDIEX;
            6'b000010: dec_next = JEX;
`ifdef MC_BNE_EN
            6'b000101: dec_next = BNEEX;
`endif
            default:   dec_legal = 1'b0;
        endcase
        if (!dec_legal) dec_next = ILLEGAL_TRAP ? HALT : FETCH;
    end

    assign illegal = (state_q == DECODE) && !dec_legal;

    // next-state and Moore control word; unreachable states fall back to FETCH
    always_comb begin
        state_d     = FETCH;
        controlword = 16'h0000;
        case (state_q)
            FETCH:   begin controlword = 16'h5010; state_d = DECODE; end
            DECODE:  begin controlword = 16'h0030; state_d = dec_next; end
            MEMADR:  begin controlword = 16'h0420; state_d = (op == 6'b101011) ? MEMWR : MEMRD; end
            MEMRD:   begin controlword = 16'h0100; state_d = MEMWB; end
            MEMWB:   begin controlword = 16'h0880; state_d = FETCH; end
            MEMWR:   begin controlword = 16'h2100; state_d = FETCH; end
            RTYPEEX: begin controlword = 16'h0402; state_d = RTYPEWB; end
            RTYPEWB: begin controlword = 16'h0840; state_d = FETCH; end
            BEQEX:   begin controlword = 16'h0605; state_d = FETCH; end
            ADDIEX:  begin controlword = 16'h0420; state_d = ADDIWB; end
            ADDIWB:  begin controlword = 16'h0800; state_d = FETCH; end
            JEX:     begin controlword = 16'h4008; state_d = FETCH; end
`ifdef MC_BNE_EN
            BNEEX:   begin controlword = 16'h8405; state_d = FETCH; end
`endif
            HALT:    begin controlword = 16'h0000; state_d = ILLEGAL_TRAP ? HALT : FETCH; end
            default: begin controlword = 16'h0000; state_d = FETCH; end
        endcase
    end

    // ALU select from aluop, with funct consulted only for aluop 10
    always_comb begin
        alucontrol = (controlword[1:0] == 2'b01) ? 3'b110 :
                     (controlword[1:0] != 2'b10) ? 3'b010 :
                     (funct == 6'b100010)        ? 3'b110 :
                     (funct == 6'b100100)        ? 3'b000 :
                     (funct == 6'b100101)        ? 3'b001 :
                     (funct == 6'b101010)        ? 3'b111 : 3'b010;
    end
endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: randomized instruction stream checked against an instruction-level reference model.
module tb_mc_controller;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        reset_t = 1'b1;
    logic [5:0]  op = 6'b100011;
    logic [5:0]  funct = 6'b000000;
    logic [3:0]  state, state_t;
    logic [15:0] cw, cw_t;
    logic [2:0]  alu, alu_t;
    logic        ill, ill_t;
    int          checks = 0;
    int          failures = 0;

`ifdef MC_BNE_EN
    localparam bit BNE = 1'b1;
`else
    localparam bit BNE = 1'b0;
`endif

    typedef int path_t[$];

    always #5 clk = ~clk;

    mc_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct),
        .state(state), .controlword(cw), .alucontrol(alu), .illegal(ill)
    );

    mc_controller #(.ILLEGAL_TRAP(1'b1)) dut_t (
        .clk(clk), .reset(reset_t), .op(op), .funct(funct),
        .state(state_t), .controlword(cw_t), .alucontrol(alu_t), .illegal(ill_t)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] cw_ref(input int s);
        case (s)
            0: return 16'h5010;
            1: return 16'h0030;
            2: return 16'h0420;
            3: return 16'h0100;
            4: return 16'h0880;
            5: return 16'h2100;
            6: return 16'h0402;
            7: return 16'h0840;
            8: return 16'h0605;
            9: return 16'h0420;
            10: return 16'h0800;
            11: return 16'h4008;
            12: return BNE ? 16'h8405 : 16'h0000;
            default: return 16'h0000;
        endcase
    endfunction

    function automatic bit legal_ref(input logic [5:0] o, input logic [5:0] f);
        if (o == 6'd0) return f inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        return (o inside {6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010}) || (BNE && o == 6'b000101);
    endfunction

    function automatic path_t path_ref(input logic [5:0] o, input logic [5:0] f);
        path_t p;
        p = '{0, 1};
        if (!legal_ref(o, f)) return p;
        case (o)
            6'b100011: p = {p, 2, 3, 4};
            6'b101011: p = {p, 2, 5};
            6'b000000: p = {p, 6, 7};
            6'b000100: p.push_back(8);
            6'b001000: p = {p, 9, 10};
            6'b000010: p.push_back(11);
            default:   p.push_back(12);
        endcase
        return p;
    endfunction

    function automatic logic [2:0] alu_ref(input logic [1:0] aluop, input logic [5:0] f);
        if (aluop == 2'b01) return 3'b110;
        if (aluop != 2'b10) return 3'b010;
        case (f)
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    task automatic run_instr(input logic [5:0] o, input logic [5:0] f);
        path_t p;
        logic [15:0] ecw;
        op = o;
        funct = f;
        p = path_ref(o, f);
        foreach (p[i]) begin
            ecw = cw_ref(p[i]);
            chk($sformatf("op%02h/%02h c%0d state", o, f, i), 32'(state), 32'(p[i]));
            chk($sformatf("op%02h/%02h c%0d cw", o, f, i), 32'(cw), 32'(ecw));
            chk($sformatf("op%02h/%02h c%0d illegal", o, f, i), 32'(ill), 32'(p[i] == 1 && !legal_ref(o, f)));
            chk($sformatf("op%02h/%02h c%0d alu", o, f, i), 32'(alu), 32'(alu_ref(ecw[1:0], f)));
            @(negedge clk);
        end
    endtask

    initial begin
        logic [5:0] ops[8];
        logic [5:0] rf[5];
        logic [5:0] o, f;
        ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010, 6'b000101, 6'b111111};
        rf = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        @(negedge clk);
        @(negedge clk);
        chk("reset state", 32'(state), 32'd0);
        chk("reset cw", 32'(cw), 32'h5010);
        chk("reset illegal", 32'(ill), 32'd0);
        #2 reset = 1'b0;
        run_instr(6'b100011, 6'b000000);
        run_instr(6'b101011, 6'b000000);
        run_instr(6'b000000, 6'b100010);
        run_instr(6'b000000, 6'b101010);
        run_instr(6'b000000, 6'b000111);
        run_instr(6'b000101, 6'b000000);
        run_instr(6'b111111, 6'b000000);
        run_instr(6'b000100, 6'b100010);
        run_instr(6'b000010, 6'b101010);
        for (int n = 0; n < 300; n++) begin
            o = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 7)];
            f = ($urandom_range(0, 4) == 0) ? 6'($urandom) : rf[$urandom_range(0, 4)];
            run_instr(o, f);
        end
        op = 6'b100011;
        chk("midrst fetch", 32'(state), 32'd0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("midrst memrd", 32'(state), 32'd3);
        #2 reset = 1'b1;
        #1;
        chk("midrst async state", 32'(state), 32'd0);
        chk("midrst async cw", 32'(cw), 32'h5010);
        @(negedge clk);
        #2 reset = 1'b0;
        run_instr(6'b100011, 6'b000000);
        run_instr(6'b000000, 6'b100100);
        op = 6'b111111;
        #2 reset_t = 1'b0;
        @(negedge clk);
        chk("trap decode state", 32'(state_t), 32'd1);
        chk("trap decode illegal", 32'(ill_t), 32'd1);
        chk("trap decode cw", 32'(cw_t), 32'h0030);
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            chk($sformatf("halt c%0d state", n), 32'(state_t), 32'hF);
            chk($sformatf("halt c%0d cw", n), 32'(cw_t), 32'h0000);
            chk($sformatf("halt c%0d illegal", n), 32'(ill_t), 32'd0);
        end
        #2 reset_t = 1'b1;
        #1;
        chk("halt async rst state", 32'(state_t), 32'd0);
        chk("halt async rst cw", 32'(cw_t), 32'h5010);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
